// File: rtl/temp_monitor.sv
// temp_monitor: smooths LM75 samples with a power-of-two boxcar average, then
// applies an over-temperature threshold with hysteresis and a consecutive-fault
// qualifier. Drives a level alarm and a sticky interrupt.
// Optional min/max tracking of the average is built when TEMP_MON_MINMAX_EN is defined.
module temp_monitor #(
  parameter int FAULT_QUEUE = 4,
  parameter int AVG_LOG2    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [8:0] sample_data,
  input  logic [8:0] tos,
  input  logic [8:0] thyst,
  input  logic       irq_mode,
  input  logic       irq_clr,
  input  logic       minmax_clr,
  output logic [8:0] avg_temp,
  output logic       avg_valid,
  output logic       alarm,
  output logic       irq,
  output logic [8:0] min_temp,
  output logic [8:0] max_temp
);

  localparam int WIN = 1 << AVG_LOG2;
  localparam int SW  = 9 + AVG_LOG2;
  localparam logic [3:0] FQ = 4'(FAULT_QUEUE);

  typedef enum logic [1:0] {
    EMPTY,
    NORMAL,
    HOT
  } state_t;

  logic signed [8:0]    window [WIN];
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] next_sum;
  logic                 primed;
  logic signed [8:0]    sample_s;
  logic signed [SW-1:0] sample_ext;
  logic signed [SW-1:0] oldest_ext;

  logic signed [8:0]    avg_s;
  logic signed [8:0]    tos_s;
  logic signed [8:0]    thyst_s;

  state_t               state;
  state_t               state_nx;
  state_t               eval_state;
  logic [3:0]           count;
  logic [3:0]           count_nx;
  logic [3:0]           base;
  logic                 qualify;
  logic                 flip;

  assign sample_s   = sample_data;
  assign sample_ext = SW'(sample_s);
  assign oldest_ext = SW'(window[WIN-1]);
  assign avg_s      = avg_temp;
  assign tos_s      = tos;
  assign thyst_s    = thyst;

  // Running sum: the first sample preloads the whole window, later ones slide it.
  always_comb begin
    next_sum = sum;
    if (primed) begin
      next_sum = sum + sample_ext - oldest_ext;
    end else begin
      next_sum = sample_ext <<< AVG_LOG2;
    end
  end

  // Window shift register and sum; an unprimed window is filled with the new sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) begin
        window[i] <= '0;
      end
      sum    <= '0;
      primed <= 1'b0;
    end else if (sample_valid) begin
      window[0] <= sample_s;
      for (int i = 1; i < WIN; i++) begin
        window[i] <= primed ? window[i-1] : sample_s;
      end
      sum    <= next_sum;
      primed <= 1'b1;
    end
  end

  // Average register: arithmetic shift floors toward minus infinity.
  always_ff @(posedge clk) begin
    if (rst) begin
      avg_temp  <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= sample_valid;
      if (sample_valid) begin
        avg_temp <= 9'(next_sum >>> AVG_LOG2);
      end
    end
  end

  // Alarm FSM next state: EMPTY behaves as NORMAL with a fresh counter on its first evaluation.
  always_comb begin
    state_nx   = state;
    count_nx   = count;
    flip       = 1'b0;
    eval_state = state;
    base       = count;
    qualify    = 1'b0;
    if (avg_valid) begin
      eval_state = (state == HOT) ? HOT : NORMAL;
      base       = (state == EMPTY) ? 4'd0 : count;
      qualify    = (eval_state == HOT) ? (avg_s < thyst_s) : (avg_s >= tos_s);
      state_nx   = eval_state;
      count_nx   = '0;
      if (qualify) begin
        if (base + 4'd1 == FQ) begin
          state_nx = (eval_state == HOT) ? NORMAL : HOT;
          flip     = 1'b1;
        end else begin
          count_nx = base + 4'd1;
        end
      end
    end
  end

  // Alarm FSM state and fault counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  assign alarm = (state == HOT);

  // Sticky interrupt: a transition set beats a same-cycle clear; comparator mode holds it low.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (!irq_mode) begin
      irq <= 1'b0;
    end else if (flip) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end

`ifdef TEMP_MON_MINMAX_EN
  logic mm_fresh;

  // Min/max of the average; the first average after reset or a clear seeds both.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_temp <= '0;
      max_temp <= '0;
      mm_fresh <= 1'b1;
    end else if (avg_valid) begin
      if (mm_fresh || minmax_clr) begin
        min_temp <= avg_temp;
        max_temp <= avg_temp;
      end else begin
        if (avg_s < $signed(min_temp)) begin
          min_temp <= avg_temp;
        end
        if (avg_s > $signed(max_temp)) begin
          max_temp <= avg_temp;
        end
      end
      mm_fresh <= 1'b0;
    end else if (minmax_clr) begin
      mm_fresh <= 1'b1;
    end
  end
`else
  logic unused_minmax_clr;

  assign unused_minmax_clr = minmax_clr;
  assign min_temp          = '0;
  assign max_temp          = '0;
`endif

endmodule

// File: tb/tb_temp_monitor.sv
// tb_temp_monitor: directed stimulus for two temp_monitor instances (4-sample and
// 1-sample windows) checked every cycle against a queue-free reference model,
// plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_temp_monitor;

  localparam int FQ    = 4;
  localparam int TOS   = 160;
  localparam int THYST = 150;
`ifdef TEMP_MON_MINMAX_EN
  localparam bit MM_EN = 1'b1;
`else
  localparam bit MM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_valid;
  logic [8:0] sample_data;
  logic [8:0] tos;
  logic [8:0] thyst;
  logic       irq_mode;
  logic       irq_clr;
  logic       minmax_clr;

  logic [8:0] avg_temp_o [2];
  logic       avg_valid_o [2];
  logic       alarm_o [2];
  logic       irq_o [2];
  logic [8:0] min_temp_o [2];
  logic [8:0] max_temp_o [2];

  int checks = 0;
  int passes = 0;
  bit started = 1'b0;

  int m_avg [2];
  bit m_valid [2];
  bit m_hot [2];
  int m_streak [2];
  bit m_irq [2];
  int m_min [2];
  int m_max [2];
  bit m_fresh [2];
  bit m_primed [2];
  int hist [2][16];

  always #5 clk = ~clk;

  temp_monitor #(.FAULT_QUEUE(FQ), .AVG_LOG2(2)) dut_box (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .tos(tos), .thyst(thyst), .irq_mode(irq_mode), .irq_clr(irq_clr), .minmax_clr(minmax_clr),
    .avg_temp(avg_temp_o[0]), .avg_valid(avg_valid_o[0]), .alarm(alarm_o[0]), .irq(irq_o[0]),
    .min_temp(min_temp_o[0]), .max_temp(max_temp_o[0])
  );

  temp_monitor #(.FAULT_QUEUE(FQ), .AVG_LOG2(0)) dut_raw (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .tos(tos), .thyst(thyst), .irq_mode(irq_mode), .irq_clr(irq_clr), .minmax_clr(minmax_clr),
    .avg_temp(avg_temp_o[1]), .avg_valid(avg_valid_o[1]), .alarm(alarm_o[1]), .irq(irq_o[1]),
    .min_temp(min_temp_o[1]), .max_temp(max_temp_o[1])
  );

  // One comparison: count it, report it if it differs.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int sx(input logic [8:0] v);
    return int'($signed(v));
  endfunction

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int win_len(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // Reference model: average of the last N samples, threshold streaks, sticky irq, min/max.
  task automatic model_step();
    bit flip;
    int s;
    int total;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_primed[d] = 1'b0;
        m_avg[d]    = 0;
        m_valid[d]  = 1'b0;
        m_hot[d]    = 1'b0;
        m_streak[d] = 0;
        m_irq[d]    = 1'b0;
        m_min[d]    = 0;
        m_max[d]    = 0;
        m_fresh[d]  = 1'b1;
        for (int i = 0; i < 16; i++) hist[d][i] = 0;
      end else begin
        flip = 1'b0;
        if (m_valid[d]) begin
          if (m_hot[d] ? (m_avg[d] < THYST) : (m_avg[d] >= TOS)) m_streak[d]++;
          else m_streak[d] = 0;
          if (m_streak[d] == FQ) begin
            m_hot[d]    = !m_hot[d];
            m_streak[d] = 0;
            flip        = 1'b1;
          end
        end
        if (!irq_mode) m_irq[d] = 1'b0;
        else if (flip) m_irq[d] = 1'b1;
        else if (irq_clr) m_irq[d] = 1'b0;
        if (m_valid[d]) begin
          if (m_fresh[d] || minmax_clr) begin
            m_min[d] = m_avg[d];
            m_max[d] = m_avg[d];
          end else begin
            if (m_avg[d] < m_min[d]) m_min[d] = m_avg[d];
            if (m_avg[d] > m_max[d]) m_max[d] = m_avg[d];
          end
          m_fresh[d] = 1'b0;
        end else if (minmax_clr) begin
          m_fresh[d] = 1'b1;
        end
        if (sample_valid) begin
          s = sx(sample_data);
          if (!m_primed[d]) begin
            for (int i = 0; i < win_len(d); i++) hist[d][i] = s;
          end else begin
            for (int i = win_len(d) - 1; i > 0; i--) hist[d][i] = hist[d][i-1];
            hist[d][0] = s;
          end
          total = 0;
          for (int i = 0; i < win_len(d); i++) total += hist[d][i];
          m_avg[d]    = floor_div(total, win_len(d));
          m_valid[d]  = 1'b1;
          m_primed[d] = 1'b1;
        end else begin
          m_valid[d] = 1'b0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of both instances against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("avg_temp[%0d]", d), sx(avg_temp_o[d]), m_avg[d]);
        checkOutput($sformatf("avg_valid[%0d]", d), int'(avg_valid_o[d]), int'(m_valid[d]));
        checkOutput($sformatf("alarm[%0d]", d), int'(alarm_o[d]), int'(m_hot[d]));
        checkOutput($sformatf("irq[%0d]", d), int'(irq_o[d]), int'(m_irq[d]));
        checkOutput($sformatf("min_temp[%0d]", d), sx(min_temp_o[d]), MM_EN ? m_min[d] : 0);
        checkOutput($sformatf("max_temp[%0d]", d), sx(max_temp_o[d]), MM_EN ? m_max[d] : 0);
      end
    end
  end

  // Drive one cycle of inputs from a negedge; strobes drop again afterwards.
  task automatic applyStimulus(input int data, input bit valid, input bit clr_irq, input bit clr_mm);
    sample_data  = 9'(data);
    sample_valid = valid;
    irq_clr      = clr_irq;
    minmax_clr   = clr_mm;
    @(negedge clk);
    sample_valid = 1'b0;
    irq_clr      = 1'b0;
    minmax_clr   = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic hysteresisRun(input bit check_irq);
    repeat (3) applyStimulus(170, 1'b1, 1'b0, 1'b0);
    applyStimulus(100, 1'b1, 1'b0, 1'b0);
    repeat (2) applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("hys_no_alarm_after_3", int'(alarm_o[1]), 0);
    repeat (4) applyStimulus(170, 1'b1, 1'b0, 1'b0);
    checkOutput("hys_alarm_not_yet", int'(alarm_o[1]), 0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("hys_alarm_set", int'(alarm_o[1]), 1);
    if (check_irq) begin
      checkOutput("irq_set_on_hot", int'(irq_o[1]), 1);
      applyStimulus(0, 1'b0, 1'b1, 1'b0);
      checkOutput("irq_cleared", int'(irq_o[1]), 0);
    end
    repeat (4) applyStimulus(155, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("hys_alarm_held", int'(alarm_o[1]), 1);
    repeat (4) applyStimulus(140, 1'b1, 1'b0, 1'b0);
    checkOutput("hys_alarm_still_held", int'(alarm_o[1]), 1);
    applyStimulus(0, 1'b0, check_irq, 1'b0);
    checkOutput("hys_alarm_released", int'(alarm_o[1]), 0);
    if (check_irq) begin
      checkOutput("irq_set_beats_clr", int'(irq_o[1]), 1);
    end
  endtask

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    tos          = 9'(TOS);
    thyst        = 9'(THYST);
    irq_mode     = 1'b0;
    irq_clr      = 1'b0;
    minmax_clr   = 1'b0;
    @(negedge clk);
    started = 1'b1;
    checkOutput("reset_avg", sx(avg_temp_o[0]), 0);
    checkOutput("reset_alarm", int'(alarm_o[0]), 0);
    checkOutput("reset_irq", int'(irq_o[0]), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] preload");
    applyStimulus(50, 1'b1, 1'b0, 1'b0);
    checkOutput("preload_avg", sx(avg_temp_o[0]), 50);
    checkOutput("preload_valid", int'(avg_valid_o[0]), 1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("preload_valid_drop", int'(avg_valid_o[0]), 0);

    $display("[TB] boxcar");
    doReset();
    applyStimulus(40, 1'b1, 1'b0, 1'b0);
    checkOutput("box_avg_1", sx(avg_temp_o[0]), 40);
    applyStimulus(40, 1'b1, 1'b0, 1'b0);
    checkOutput("box_avg_2", sx(avg_temp_o[0]), 40);
    applyStimulus(40, 1'b1, 1'b0, 1'b0);
    checkOutput("box_avg_3", sx(avg_temp_o[0]), 40);
    applyStimulus(80, 1'b1, 1'b0, 1'b0);
    checkOutput("box_avg_4", sx(avg_temp_o[0]), 50);
    applyStimulus(-20, 1'b1, 1'b0, 1'b0);
    checkOutput("box_avg_neg", sx(avg_temp_o[0]), 35);
    doReset();
    applyStimulus(-3, 1'b1, 1'b0, 1'b0);
    checkOutput("box_neg_preload", sx(avg_temp_o[0]), -3);
    checkOutput("raw_neg_preload", sx(avg_temp_o[1]), -3);

    $display("[TB] hysteresis, comparator mode");
    doReset();
    irq_mode = 1'b0;
    hysteresisRun(1'b0);
    checkOutput("cmp_irq_low", int'(irq_o[1]), 0);

    $display("[TB] hysteresis, interrupt mode");
    irq_mode = 1'b1;
    doReset();
    hysteresisRun(1'b1);

    $display("[TB] min/max");
    irq_mode = 1'b0;
    doReset();
    applyStimulus(30, 1'b1, 1'b0, 1'b0);
    applyStimulus(-10, 1'b1, 1'b0, 1'b0);
    applyStimulus(90, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("mm_min", sx(min_temp_o[1]), MM_EN ? -10 : 0);
    checkOutput("mm_max", sx(max_temp_o[1]), MM_EN ? 90 : 0);
    applyStimulus(20, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput("mm_clr_min", sx(min_temp_o[1]), MM_EN ? 20 : 0);
    checkOutput("mm_clr_max", sx(max_temp_o[1]), MM_EN ? 20 : 0);

    $display("[TB] mid-run reset");
    irq_mode = 1'b1;
    doReset();
    repeat (4) applyStimulus(170, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_hot", int'(alarm_o[1]), 1);
    rst          = 1'b1;
    sample_data  = 9'(170);
    sample_valid = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    sample_valid = 1'b0;
    checkOutput("midrst_alarm", int'(alarm_o[1]), 0);
    checkOutput("midrst_irq", int'(irq_o[1]), 0);
    checkOutput("midrst_avg", sx(avg_temp_o[1]), 0);
    checkOutput("midrst_valid", int'(avg_valid_o[1]), 0);
    applyStimulus(100, 1'b1, 1'b0, 1'b0);
    checkOutput("midrst_first_sample", sx(avg_temp_o[0]), 100);
    repeat (3) applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_normal", int'(alarm_o[1]), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
